// File: rtl/layer_sched_pkg.sv
// Shared definitions for the layer scheduler: opcodes, engine indices and
// the one-hot sequencer state encoding.
package layer_sched_pkg;

    typedef enum logic [1:0] {
        OP_END  = 2'd0,
        OP_CONV = 2'd1,
        OP_POOL = 2'd2,
        OP_RELU = 2'd3
    } op_e;

    localparam int unsigned ENG_CONV = 0;
    localparam int unsigned ENG_POOL = 1;
    localparam int unsigned ENG_RELU = 2;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_LAUNCH = 6'b000010,
        ST_RUN    = 6'b000100,
        ST_DRAIN  = 6'b001000,
        ST_NEXT   = 6'b010000,
        ST_FIN    = 6'b100000
    } state_e;

    function automatic int unsigned op_to_eng(input op_e op);
        case (op)
            OP_CONV: return ENG_CONV;
            OP_POOL: return ENG_POOL;
            OP_RELU: return ENG_RELU;
            default: return ENG_CONV;
        endcase
    endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Control, engine and DRAM signal bundle around the layer scheduler.
// master = host/engine side, slave = the scheduler itself.
interface layer_sched_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned NUM_ENG    = 3,
    parameter int unsigned PROG_DEPTH = 8
);
    localparam int unsigned IDX_W = $clog2(PROG_DEPTH);

    logic                          start;
    logic                          prog_we;
    logic [IDX_W-1:0]              prog_addr;
    logic [1:0]                    prog_op;
    logic                          busy;
    logic                          done;
    logic                          err;
    logic [IDX_W-1:0]              layer_idx;
    logic [NUM_ENG-1:0]            eng_enable;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_in;
    logic [NUM_ENG*ADDR_WIDTH-1:0] eng_addr_out;
    logic [NUM_ENG*DATA_WIDTH-1:0] eng_data_out;
    logic [NUM_ENG-1:0]            eng_en_rd;
    logic [NUM_ENG-1:0]            eng_en_wr;
    logic [ADDR_WIDTH-1:0]         dram_addr_rd;
    logic [ADDR_WIDTH-1:0]         dram_addr_wr;
    logic [DATA_WIDTH-1:0]         dram_data_wr;
    logic                          dram_en_rd;
    logic                          dram_en_wr;

    modport master (
        output start, prog_we, prog_addr, prog_op,
        output eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr,
        input  busy, done, err, layer_idx, eng_enable,
        input  dram_addr_rd, dram_addr_wr, dram_data_wr, dram_en_rd, dram_en_wr
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_op,
        input  eng_done, eng_addr_in, eng_addr_out, eng_data_out, eng_en_rd, eng_en_wr,
        output busy, done, err, layer_idx, eng_enable,
        output dram_addr_rd, dram_addr_wr, dram_data_wr, dram_en_rd, dram_en_wr
    );

endinterface

// File: rtl/layer_sched_dram_port_mux.sv
// Grant-indexed mux from the per-engine DRAM request slices onto the single
// DRAM port; everything reads zero when no grant is active.
module dram_port_mux #(
    parameter int unsigned NUM_ENG    = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned GRANT_W    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
    input  logic                          i_active,
    input  logic [GRANT_W-1:0]            i_grant,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] i_addr_in,
    input  logic [NUM_ENG*ADDR_WIDTH-1:0] i_addr_out,
    input  logic [NUM_ENG*DATA_WIDTH-1:0] i_data_out,
    input  logic [NUM_ENG-1:0]            i_en_rd,
    input  logic [NUM_ENG-1:0]            i_en_wr,
    output logic [ADDR_WIDTH-1:0]         o_addr_rd,
    output logic [ADDR_WIDTH-1:0]         o_addr_wr,
    output logic [DATA_WIDTH-1:0]         o_data_wr,
    output logic                          o_en_rd,
    output logic                          o_en_wr
);

    always_comb begin
        o_addr_rd = '0;
        o_addr_wr = '0;
        o_data_wr = '0;
        o_en_rd   = 1'b0;
        o_en_wr   = 1'b0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (i_active && (i_grant == GRANT_W'(i))) begin
                o_addr_rd = i_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                o_addr_wr = i_addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
                o_data_wr = i_data_out[i*DATA_WIDTH +: DATA_WIDTH];
                o_en_rd   = i_en_rd[i];
                o_en_wr   = i_en_wr[i];
            end
        end
    end

endmodule

// File: rtl/layer_sched.sv
// Network-level sequencer: walks a small layer program, pulses one engine
// enable per layer, waits for its done and owns the shared DRAM port.
module layer_sched #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned NUM_ENG     = 3,
    parameter int unsigned PROG_DEPTH  = 8,
    parameter int unsigned TIMEOUT_CYC = 2**20
) (
    input  logic          clk,
    input  logic          srst,
    layer_sched_if.slave  bus
);
    import layer_sched_pkg::*;

    localparam int unsigned IDX_W   = $clog2(PROG_DEPTH);
    localparam int unsigned GRANT_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYC);

    state_e             r_state;
    state_e             w_state_nxt;
    op_e                r_prog [PROG_DEPTH];
    logic [IDX_W-1:0]   r_layer_idx;
    logic [GRANT_W-1:0] r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    op_e                w_op;
    logic               w_grant_done;
    logic               w_timeout;
    logic               w_active;
    logic               w_last_entry;

    assign w_op         = r_prog[r_layer_idx];
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_active     = (r_state == ST_LAUNCH) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_last_entry = (r_layer_idx == IDX_W'(PROG_DEPTH - 1));

    // Only the granted engine's done pulse is visible to the sequencer.
    always_comb begin
        w_grant_done = 1'b0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            if (r_grant == GRANT_W'(i)) begin
                w_grant_done = bus.eng_done[i];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.busy       = (r_state != ST_IDLE);
        bus.done       = (r_state == ST_FIN);
        bus.eng_enable = '0;
        for (int unsigned i = 0; i < NUM_ENG; i++) begin
            bus.eng_enable[i] = (r_state == ST_LAUNCH) && (r_grant == GRANT_W'(i));
        end
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = ST_NEXT;
            ST_NEXT:   w_state_nxt = (w_op == OP_END) ? ST_FIN : ST_LAUNCH;
            ST_LAUNCH: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_grant_done) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN:  w_state_nxt = w_last_entry ? ST_FIN : ST_NEXT;
            ST_FIN:    w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state     <= ST_IDLE;
            r_layer_idx <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_err       <= 1'b0;
                        r_layer_idx <= '0;
                    end
                end
                ST_NEXT: begin
                    if (w_op != OP_END) begin
                        r_grant <= GRANT_W'(op_to_eng(w_op));
                    end
                end
                ST_LAUNCH: r_cnt <= '0;
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_grant_done && w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!w_last_entry) begin
                        r_layer_idx <= r_layer_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Program writes land in IDLE only, so a same-cycle start sees the new entry.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int unsigned i = 0; i < PROG_DEPTH; i++) begin
                r_prog[i] <= OP_END;
            end
        end else if ((r_state == ST_IDLE) && bus.prog_we) begin
            r_prog[bus.prog_addr] <= op_e'(bus.prog_op);
        end
    end

    assign bus.err       = r_err;
    assign bus.layer_idx = r_layer_idx;

    dram_port_mux #(
        .NUM_ENG    (NUM_ENG),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .GRANT_W    (GRANT_W)
    ) u_dram_port_mux (
        .i_active   (w_active),
        .i_grant    (r_grant),
        .i_addr_in  (bus.eng_addr_in),
        .i_addr_out (bus.eng_addr_out),
        .i_data_out (bus.eng_data_out),
        .i_en_rd    (bus.eng_en_rd),
        .i_en_wr    (bus.eng_en_wr),
        .o_addr_rd  (bus.dram_addr_rd),
        .o_addr_wr  (bus.dram_addr_wr),
        .o_data_wr  (bus.dram_data_wr),
        .o_en_rd    (bus.dram_en_rd),
        .o_en_wr    (bus.dram_en_wr)
    );

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: one default-timeout instance for program
// flow and one 16-cycle-timeout instance for the error path.
module tb_layer_sched;
    import layer_sched_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 18;
    localparam int unsigned NE = 3;
    localparam int unsigned PD = 8;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    layer_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .PROG_DEPTH(PD)) bus ();
    layer_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .PROG_DEPTH(PD)) bus2 ();

    layer_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .PROG_DEPTH(PD),
                  .TIMEOUT_CYC(2**20)) u_dut (.clk(clk), .srst(srst), .bus(bus));
    layer_sched #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_ENG(NE), .PROG_DEPTH(PD),
                  .TIMEOUT_CYC(16)) u_dut_to (.clk(clk), .srst(srst), .bus(bus2));

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.done) n_done++;
    endtask

    task automatic prog(input int unsigned a, input op_e op);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'(a);
        bus.prog_op   = op;
        step();
        bus.prog_we   = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_en [3];
        int dn0, launches, idx_at_done;
        bit got, pend;
        exp_en = '{3'b001, 3'b010, 3'b100};

        bus.start = 0; bus.prog_we = 0; bus.prog_addr = '0; bus.prog_op = '0; bus.eng_done = '0;
        bus.eng_addr_in  = {18'h00102, 18'h00101, 18'h00100};
        bus.eng_addr_out = {18'h00202, 18'h00201, 18'h00200};
        bus.eng_data_out = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        bus.eng_en_rd = 3'b111; bus.eng_en_wr = 3'b110;
        bus2.start = 0; bus2.prog_we = 0; bus2.prog_addr = '0; bus2.prog_op = '0; bus2.eng_done = '0;
        bus2.eng_addr_in = '0; bus2.eng_addr_out = '0; bus2.eng_data_out = '0;
        bus2.eng_en_rd = '0; bus2.eng_en_wr = '0;

        // reset
        srst = 1'b1;
        step(); step();
        srst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_idx", bus.layer_idx, 0);
        chk("rst_enable", bus.eng_enable, 0);
        chk("rst_en_rd", bus.dram_en_rd, 0);
        chk("rst_addr_rd", bus.dram_addr_rd, 0);

        // program {RELU, END}, done 40 cycles after the enable
        prog(0, OP_RELU);
        prog(1, OP_END);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t1_busy_t1", bus.busy, 1);
        chk("t1_enable_t1", bus.eng_enable, 3'b000);
        chk("t1_en_rd_next", bus.dram_en_rd, 0);
        step();
        chk("t1_enable_t2", bus.eng_enable, 3'b100);
        chk("t1_addr_rd_launch", bus.dram_addr_rd, 18'h00102);
        step();
        chk("t1_enable_pulse", bus.eng_enable, 3'b000);
        chk("t1_en_wr_run", bus.dram_en_wr, 1);
        repeat (39) step();
        bus.eng_done = 3'b100;
        step();
        bus.eng_done = 3'b000;
        chk("t1_drain_busy", bus.busy, 1);
        chk("t1_drain_addr_wr", bus.dram_addr_wr, 18'h00202);
        chk("t1_drain_data", bus.dram_data_wr, 32'hA5A5_0002);
        chk("t1_drain_en_wr", bus.dram_en_wr, 1);
        step();
        chk("t1_next_en_rd", bus.dram_en_rd, 0);
        chk("t1_next_addr_rd", bus.dram_addr_rd, 0);
        chk("t1_next_idx", bus.layer_idx, 1);
        step();
        chk("t1_done", bus.done, 1);
        step();
        chk("t1_done_pulse", bus.done, 0);
        chk("t1_busy_after", bus.busy, 0);

        // program {CONV, POOL, RELU, END}, with a spurious pool done during conv
        prog(0, OP_CONV);
        prog(1, OP_POOL);
        prog(2, OP_RELU);
        prog(3, OP_END);
        dn0 = n_done;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t2_next_idx", bus.layer_idx, 64'(k));
            chk("t2_next_en_rd", bus.dram_en_rd, 0);
            chk("t2_next_en_wr", bus.dram_en_wr, 0);
            step();
            chk("t2_enable", bus.eng_enable, exp_en[k]);
            if (k == 0) begin
                step(); step();
                bus.eng_done = 3'b010;
                step();
                bus.eng_done = 3'b000;
                chk("t3_en_wr_conv_only", bus.dram_en_wr, 0);
                chk("t3_addr_rd_conv", bus.dram_addr_rd, 18'h00100);
                step();
                chk("t3_still_run_en_rd", bus.dram_en_rd, 1);
                chk("t3_still_run_addr", bus.dram_addr_rd, 18'h00100);
                repeat (6) step();
            end else begin
                repeat (10) step();
            end
            bus.eng_done = exp_en[k];
            step();
            bus.eng_done = 3'b000;
            chk("t2_drain_en_rd", bus.dram_en_rd, 1);
            step();
        end
        chk("t2_end_idx", bus.layer_idx, 3);
        chk("t2_end_en_rd", bus.dram_en_rd, 0);
        step();
        chk("t2_done", bus.done, 1);
        step();
        chk("t2_busy_after", bus.busy, 0);
        chk("t2_one_done", 64'(n_done - dn0), 1);

        // timeout on the 16-cycle instance
        bus2.prog_we = 1'b1; bus2.prog_addr = 3'd0; bus2.prog_op = OP_CONV;
        step();
        bus2.prog_we = 1'b0;
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        step();
        chk("t4_enable", bus2.eng_enable, 3'b001);
        repeat (15) step();
        chk("t4_err_before", bus2.err, 0);
        chk("t4_busy_before", bus2.busy, 1);
        step();
        chk("t4_no_done_a", bus2.done, 0);
        step();
        chk("t4_err", bus2.err, 1);
        chk("t4_idle", bus2.busy, 0);
        chk("t4_no_done_b", bus2.done, 0);
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        chk("t4_err_cleared", bus2.err, 0);
        chk("t4_restart_busy", bus2.busy, 1);

        // eight RELU entries with no END
        for (int a = 0; a < 8; a++) prog(a, OP_RELU);
        launches = 0; got = 0; pend = 0; idx_at_done = 0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            step();
            if (bus.done) begin
                got = 1;
                idx_at_done = int'(bus.layer_idx);
            end
            bus.eng_done = pend ? 3'b100 : 3'b000;
            pend = (bus.eng_enable == 3'b100);
            if (pend) launches++;
        end
        bus.eng_done = 3'b000;
        chk("t5_done_seen", got, 1);
        chk("t5_launches", launches, 8);
        chk("t5_idx_at_done", idx_at_done, 7);
        step();
        chk("t5_busy_after", bus.busy, 0);

        // srst during RUN of layer 1
        prog(0, OP_CONV);
        prog(1, OP_POOL);
        prog(2, OP_END);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        bus.eng_done = 3'b001;
        step();
        bus.eng_done = 3'b000;
        step(); step();
        chk("t6_enable_pool", bus.eng_enable, 3'b010);
        step();
        chk("t6_run_idx", bus.layer_idx, 1);
        chk("t6_run_addr_rd", bus.dram_addr_rd, 18'h00101);
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_en_rd", bus.dram_en_rd, 0);
        chk("t6_addr_rd", bus.dram_addr_rd, 0);
        chk("t6_addr_wr", bus.dram_addr_wr, 0);
        chk("t6_data_wr", bus.dram_data_wr, 0);
        chk("t6_idx", bus.layer_idx, 0);
        chk("t6_enable", bus.eng_enable, 0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_op = OP_RELU;
        chk("t6_busy_t1", bus.busy, 1);
        step();
        bus.prog_we = 1'b0;
        chk("t6_empty_done", bus.done, 1);
        step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        chk("t6_busy_write_ignored", bus.done, 1);
        chk("t6_no_enable", bus.eng_enable, 0);
        step();
        chk("t6_busy_after", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
